// File: rtl/tiny_8_bit_cpu.sv
// Single-cycle RV32I-subset demo CPU: fixed 16-word ROM, 16-word data RAM,
// one instruction per rising edge of an internally divided slow clock.
module tiny_8_bit_cpu #(
  parameter int CLK_DIV = 4
) (
  input  logic CLK,
  input  logic RST,
  output logic led_red,
  output logic led_green,
  output logic led_blue
);

  localparam logic [31:0] DIV_LAST = 32'(CLK_DIV - 1);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;

  // Declaration values give the FPGA power-up state, identical to reset.
  logic [31:0] r_div_cnt = 32'd0;
  logic        slow_clk  = 1'b0;
  logic [31:0] PC        = 32'd0;
  logic [31:0] IR        = 32'd0;
  logic [31:0] R     [0:31] = '{default: 32'd0};
  logic [31:0] r_dmem [0:15] = '{default: 32'd0};

  logic        w_tick;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [31:0] w_rs1_val;
  logic [31:0] w_rs2_val;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_s;
  logic [31:0] w_imm_j;
  logic [31:0] w_addr;
  logic        w_rd_we;
  logic [31:0] w_rd_data;
  logic        w_mem_we;
  logic [31:0] w_pc_next;

  function automatic logic [31:0] rom_word(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_word = 32'h00500093;
      4'd1:    rom_word = 32'h00300113;
      4'd2:    rom_word = 32'h002081B3;
      4'd3:    rom_word = 32'h40108233;
      4'd4:    rom_word = 32'h00118293;
      4'd5:    rom_word = 32'h02A00313;
      4'd6:    rom_word = 32'h00000393;
      4'd7:    rom_word = 32'h0063A023;
      4'd8:    rom_word = 32'h0003A403;
      4'd9:    rom_word = 32'h000404B3;
      4'd10:   rom_word = 32'h0000006F;
      default: rom_word = 32'h00000013;
    endcase
  endfunction

  // A tick is the CLK edge on which slow_clk rises.
  assign w_tick = (r_div_cnt == DIV_LAST) && !slow_clk;

  assign w_instr   = rom_word(PC[5:2]);
  assign w_opcode  = w_instr[6:0];
  assign w_rd      = w_instr[11:7];
  assign w_funct3  = w_instr[14:12];
  assign w_rs1     = w_instr[19:15];
  assign w_rs2     = w_instr[24:20];
  assign w_funct7  = w_instr[31:25];
  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : R[w_rs1];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : R[w_rs2];
  assign w_imm_i   = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_j   = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20],
                      w_instr[30:21], 1'b0};

  // Decode and execute the instruction addressed by PC.
  always_comb begin
    w_rd_we   = 1'b0;
    w_rd_data = 32'd0;
    w_mem_we  = 1'b0;
    w_addr    = 32'd0;
    w_pc_next = PC + 32'd4;
    case (w_opcode)
      OPC_OP: begin
        if (w_funct3 == 3'b000 && w_funct7 == 7'b0000000) begin
          w_rd_we   = 1'b1;
          w_rd_data = w_rs1_val + w_rs2_val;
        end else if (w_funct3 == 3'b000 && w_funct7 == 7'b0100000) begin
          w_rd_we   = 1'b1;
          w_rd_data = w_rs1_val - w_rs2_val;
        end else begin
          w_rd_we   = 1'b0;
        end
      end
      OPC_IMM: begin
        if (w_funct3 == 3'b000) begin
          w_rd_we   = 1'b1;
          w_rd_data = w_rs1_val + w_imm_i;
        end else begin
          w_rd_we   = 1'b0;
        end
      end
      OPC_LOAD: begin
        w_addr = w_rs1_val + w_imm_i;
        if (w_funct3 == 3'b010) begin
          w_rd_we   = 1'b1;
          w_rd_data = r_dmem[w_addr[5:2]];
        end else begin
          w_rd_we   = 1'b0;
        end
      end
      OPC_STORE: begin
        w_addr = w_rs1_val + w_imm_s;
        if (w_funct3 == 3'b010) begin
          w_mem_we = 1'b1;
        end else begin
          w_mem_we = 1'b0;
        end
      end
      OPC_JAL: begin
        w_rd_we   = 1'b1;
        w_rd_data = PC + 32'd4;
        w_pc_next = PC + w_imm_j;
      end
      default: begin
        w_rd_we   = 1'b0;
      end
    endcase
  end

  // Clock divider producing slow_clk.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_cnt <= 32'd0;
      slow_clk  <= 1'b0;
    end else if (r_div_cnt == DIV_LAST) begin
      r_div_cnt <= 32'd0;
      slow_clk  <= ~slow_clk;
    end else begin
      r_div_cnt <= r_div_cnt + 32'd1;
    end
  end

  // Architectural state update, once per tick; reset wins over a tick.
  always_ff @(posedge CLK) begin
    if (RST) begin
      PC <= 32'd0;
      IR <= 32'd0;
      for (int i = 0; i < 32; i++) R[i] <= 32'd0;
      for (int j = 0; j < 16; j++) r_dmem[j] <= 32'd0;
    end else if (w_tick) begin
      IR <= w_instr;
      PC <= w_pc_next;
      if (w_rd_we && w_rd != 5'd0) R[w_rd] <= w_rd_data;
      if (w_mem_we) r_dmem[w_addr[5:2]] <= w_rs2_val;
    end
  end

  assign led_red   = ~R[5][0];
  assign led_green = ~R[5][1];
  assign led_blue  = ~R[5][2];

endmodule

// File: tb/tb_tiny_8_bit_cpu.sv
// Directed bench for tiny_8_bit_cpu: per-tick PC/IR/LED scoreboard, final
// register values, reset mid-run, and the CLK_DIV=1 divider.
module tb_tiny_8_bit_cpu;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic led_red, led_green, led_blue;
  logic led1_red, led1_green, led1_blue;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [2:0]  led;
  } exp_t;
  exp_t sb[$];

  logic [31:0] rom  [0:10] = '{32'h00500093, 32'h00300113, 32'h002081B3,
                               32'h40108233, 32'h00118293, 32'h02A00313,
                               32'h00000393, 32'h0063A023, 32'h0003A403,
                               32'h000404B3, 32'h0000006F};
  logic [31:0] xfin [0:9]  = '{32'd0, 32'd5, 32'd3, 32'd8, 32'd0, 32'd9,
                               32'h2A, 32'd0, 32'h2A, 32'h2A};

  tiny_8_bit_cpu #(.CLK_DIV(4)) dut (
    .CLK(CLK), .RST(RST),
    .led_red(led_red), .led_green(led_green), .led_blue(led_blue)
  );

  tiny_8_bit_cpu #(.CLK_DIV(1)) dut1 (
    .CLK(CLK), .RST(RST),
    .led_red(led1_red), .led_green(led1_green), .led_blue(led1_blue)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next slow_clk rising edge, bounded; reports CLK cycles used.
  task automatic wait_tick(output bit ok, output int cyc);
    bit prev;
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      prev = dut.slow_clk;
      @(posedge CLK);
      #1;
      cyc++;
      if (prev == 1'b0 && dut.slow_clk == 1'b1) ok = 1'b1;
    end
  endtask

  task automatic run_ticks(input int n);
    exp_t e;
    bit   ok;
    int   cyc;
    for (int k = 1; k <= n; k++) begin
      e.pc  = (k <= 10) ? 32'(4 * k) : 32'd40;
      e.ir  = (k <= 10) ? rom[k-1] : 32'h0000006F;
      e.led = (k >= 5) ? 3'b110 : 3'b111;
      sb.push_back(e);
      wait_tick(ok, cyc);
      check($sformatf("tick%0d_seen", k), {31'd0, ok}, 32'd1);
      if (k > 1) check($sformatf("tick%0d_spacing", k), 32'(cyc), 32'd8);
      e = sb.pop_front();
      check($sformatf("tick%0d_pc", k), dut.PC, e.pc);
      check($sformatf("tick%0d_ir", k), dut.IR, e.ir);
      check($sformatf("tick%0d_leds", k), {29'd0, led_blue, led_green, led_red},
            {29'd0, e.led});
      if (k == 8) check("dmem0_after_sw", dut.r_dmem[0], 32'h2A);
      if (k == 9) check("x8_after_lw", dut.R[8], 32'h2A);
    end
  endtask

  task automatic check_finals(input string tag);
    for (int i = 0; i < 10; i++)
      check($sformatf("%s_x%0d", tag, i), dut.R[i], xfin[i]);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, dut.PC, 32'd0);
    check({tag, "_ir"}, dut.IR, 32'd0);
    check({tag, "_slow_clk"}, {31'd0, dut.slow_clk}, 32'd0);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_x%0d", tag, i), dut.R[i], 32'd0);
    check({tag, "_leds"}, {29'd0, led_blue, led_green, led_red}, 32'd7);
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    bit prev;
    #1;
    check_reset_state("powerup");

    run_ticks(20);
    check_finals("run1");

    pulse_reset();
    check_reset_state("reset_idle");

    run_ticks(7);
    pulse_reset();
    check_reset_state("reset_mid");

    run_ticks(20);
    check_finals("run2");

    for (int i = 0; i < 8; i++) begin
      prev = dut1.slow_clk;
      @(posedge CLK);
      #1;
      check($sformatf("div1_toggle%0d", i), {31'd0, dut1.slow_clk}, {31'd0, ~prev});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_8_bit_cpu.md
# tiny_8_bit_cpu

Single-cycle RV32I-subset CPU for an FPGA demo board. It executes a fixed program from an internal instruction ROM, one instruction per tick of an internally divided slow clock. It shows the result on three active-low RGB LED outputs. The module name is `tiny_8_bit_cpu`; it is the top level and has no bus interface.

## Interface
- `CLK_DIV`, default 4: number of `CLK` cycles per `slow_clk` half-period, ≥1. Set large (e.g. 6_000_000) for visible LEDs on hardware.
- `CLK`  in  1: system clock; the only clock in the block.
- `RST`  in  1: synchronous, active-high reset.
- `led_red`  out  1: active-low, equals `~R[5][0]`.
- `led_green`  out  1: active-low, equals `~R[5][1]`.
- `led_blue`  out  1: active-low, equals `~R[5][2]`.
- Internal signals, by these exact names (benches probe them hierarchically):
  - `slow_clk` (1 bit)
  - `PC` (32-bit byte address)
  - `IR` (32 bits)
  - `R` (32×32 register array)

## Operation
- **Divider**
  - A counter counts `CLK` cycles.
  - When the counter equals `CLK_DIV-1`: the counter returns to 0 and `slow_clk` toggles.
  - A *tick* is the `CLK` edge where `slow_clk` goes 0→1. All CPU state changes only on ticks.
- **Execution (on each tick)**
  - Fetch `ROM[PC[5:2]]`, execute it, write the result back, update `PC`, and load `IR` with the executed instruction.
  - `PC` becomes `PC+4`, except for JAL.
- **ROM**: 16 words, fixed contents. Words 11–15 are `0x00000013` (NOP).

| Word | Encoding | Instruction |
|---|---|---|
| 0 | `0x00500093` | addi x1,x0,5 |
| 1 | `0x00300113` | addi x2,x0,3 |
| 2 | `0x002081B3` | add x3,x1,x2 |
| 3 | `0x40108233` | sub x4,x1,x1 |
| 4 | `0x00118293` | addi x5,x3,1 |
| 5 | `0x02A00313` | addi x6,x0,42 |
| 6 | `0x00000393` | addi x7,x0,0 |
| 7 | `0x0063A023` | sw x6,0(x7) |
| 8 | `0x0003A403` | lw x8,0(x7) |
| 9 | `0x000404B3` | add x9,x8,x0 |
| 10 | `0x0000006F` | jal x0,0 (halt loop) |

- **Supported instructions**
  - OP (`0110011`): ADD (funct7 0) and SUB (funct7 `0100000`), funct3 000.
  - OP-IMM (`0010011`): ADDI, with sign-extended imm[11:0].
  - LOAD (`0000011`): LW, funct3 010.
  - STORE (`0100011`): SW, funct3 010, with the standard split immediate.
  - JAL (`1101111`): `rd ← PC+4`, `PC ← PC + sext(J-imm)`.
- **Unsupported encodings** act as NOP: `PC+4`, no register or memory write.
- **Arithmetic**: all 32-bit, wrapping modulo 2^32; no flags or traps.
- **x0**: reads always return 0; writes to x0 are discarded.
- **Data memory**
  - 16×32-bit words, addressed by `addr[5:2]`. `addr[1:0]` is ignored, so there are no misalignment traps. Higher bits wrap.
  - SW writes on the tick.
  - LW reads combinationally from the current memory state and writes rd on the same tick.
- **Power-up**: all state initializes to its reset values (FPGA init), so the block runs correctly without asserting `RST`.

## Timing
- **Reset values** (applied on a `CLK` edge with `RST`=1; reset overrides a coincident tick):
  - `PC`=0, `IR`=0, all `R`=0.
  - Divider counter=0, `slow_clk`=0.
  - All data-memory words = 0.
  - All LEDs = 1 (off).
- **Latency**
  - One instruction per tick; one tick = 2·`CLK_DIV` `CLK` cycles.
  - Results are visible immediately after the tick edge.
- **Reset mid-operation**: the in-flight tick is lost and execution restarts at word 0 on the first tick after release.
- **LEDs**
  - Purely combinational from `R[5]`.
  - They first change on tick 5, when x5=9: red on, green/blue off.
- **Completion**: the program finishes after 10 ticks (last write is x9 at tick 10). From tick 11 on, `PC` stays 40 and `IR` stays `0x0000006F`.
- **PC wrap**: `PC` beyond byte 63 wraps into the ROM via `PC[5:2]`.

## Test plan
- **Run to completion**
  - Stimulus: `CLK_DIV`=4, 20 ns `CLK`, no `RST`; sample at 20 `slow_clk` rising edges.
  - Expect finals: x1=5, x2=3, x3=8, x4=0, x5=9, x6=0x2A, x7=0, x8=0x2A, x9=0x2A.
- **Per-tick trace**
  - After tick k (k=1..10), `PC`=4k and `IR`=ROM[k−1].
  - From tick 11 on, `PC`=40 and `IR`=`0x0000006F`.
- **LEDs**
  - Before tick 5: R=G=B=1.
  - After tick 5: R=0, G=1, B=1.
- **Reset**
  - Stimulus: assert `RST` for 3 `CLK` cycles after tick 7.
  - Expect `PC`=0, all R=0, LEDs=1.
  - After release the full run repeats with identical final values.
- **Store/load**: after tick 8, data word 0 = 0x2A; after tick 9, x8 = 0x2A.
- **Divider**: with `CLK_DIV`=1, `slow_clk` toggles every `CLK` cycle, so consecutive ticks are 2 `CLK` cycles apart.
